// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants, MULT/DIV state encodings and a register-match helper for the
// hazard interlock block.
// Imported by hazard_md_tracker and hazard_stall_ctrl.
package hazard_stall_ctrl_pkg;

    localparam int         MD_LAT_DEF = 32;
    localparam int         CNT_W_DEF  = 8;
    localparam int         PERF_W     = 32;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A source operand depends on a destination only if the operand is actually
    // read and the destination is not the hardwired zero register.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] src,
                                     input logic       use_src);
        return use_src && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_md_tracker.sv
// MULT/DIV occupancy tracker: loads MD_LAT on issue, counts down to idle.
// Ports: clk, rst (sync, active-high), issue (launch pulse) in; md_busy out.
// md_busy is registered: high for the MD_LAT cycles following an issue.
module hazard_md_tracker
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic md_busy
);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Issue can only arrive while idle (the top stalls MULT/DIV while busy),
    // so a reload never truncates an operation in flight.
    always_comb begin
        cnt_nxt = cnt;
        if (issue) begin
            cnt_nxt = CNT_W'(MD_LAT);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        state_nxt = (cnt_nxt != '0) ? MD_BUSY : MD_IDLE;
    end

    assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: load-use, branch-in-ID and MULT/DIV stalls,
// driving PC/IF-ID enables, ID/EX bubble, IF/ID flush and MULT/DIV launch.
// Ports: ID operand/class info, EX/MEM producer info, br_taken in; pipeline
// controls out. Optional macro HAZARD_PERF_EN adds perf_stall_cnt.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       id_is_muldiv,
    input  logic       id_reads_hilo,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       br_taken,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       md_start,
    output logic       md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt
`endif
);

    logic ex_hit;
    logic mem_hit;
    logic lu;
    logic bx;
    logic bm;
    logic md;
    logic stall;

    assign ex_hit  = reg_hit(ex_rd,  id_rs, id_use_rs) || reg_hit(ex_rd,  id_rt, id_use_rt);
    assign mem_hit = reg_hit(mem_rd, id_rs, id_use_rs) || reg_hit(mem_rd, id_rt, id_use_rt);

    // The branch compare happens in ID, so any EX producer (not just loads)
    // and a load still in MEM are too late to forward into it.
    assign lu    = ex_mem_read && ex_hit;
    assign bx    = id_is_branch && ex_reg_write && ex_hit;
    assign bm    = id_is_branch && mem_mem_read && mem_hit;
    assign md    = (id_is_muldiv || id_reads_hilo) && md_busy;
    assign stall = lu || bx || bm || md;

    // Stall wins over flush: a stalled branch's operands are not valid yet,
    // so its br_taken is meaningless this cycle.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = br_taken;
        md_start    = id_is_muldiv;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            md_start    = 1'b0;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
            md_start    = 1'b0;
        end
    end

    hazard_md_tracker #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md (
        .clk     (clk),
        .rst     (rst),
        .issue   (md_start),
        .md_busy (md_busy)
    );

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (stall && (perf_stall_cnt != {PERF_W{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_is_branch = 1'b0;
    logic       id_is_muldiv = 1'b0, id_reads_hilo = 1'b0;
    logic       ex_mem_read = 1'b0, ex_reg_write = 1'b0, mem_mem_read = 1'b0;
    logic       br_taken = 1'b0;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MD_LAT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_is_branch  (id_is_branch),
        .id_is_muldiv  (id_is_muldiv),
        .id_reads_hilo (id_reads_hilo),
        .ex_mem_read   (ex_mem_read),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .br_taken      (br_taken),
        .pc_we         (pc_we),
        .ifid_we       (ifid_we),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .md_start      (md_start),
        .md_busy       (md_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       md;
        logic       hilo;
        logic       exld;
        logic       exwr;
        logic [4:0] exrd;
        logic       memld;
        logic [4:0] memrd;
        logic       taken;
    } in_t;

    // expected bit order: {pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy}
    typedef struct {
        string      name;
        in_t        in;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] RUN   = 6'b110000;
    localparam logic [5:0] STALL = 6'b000100;
    localparam logic [5:0] FLUSH = 6'b111000;
    localparam logic [5:0] RSTO  = 6'b001100;
    localparam logic [5:0] ALL   = 6'b111111;

    vec_t       vecs[16];
    logic [5:0] exp_q[$];
    logic [5:0] msk_q[$];
    string      nm_q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_stalls = 0;
    in_t        idle;

    wire [5:0] obs = {pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy};

    function automatic in_t vin(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic br,
                                input logic md, input logic hilo, input logic exld,
                                input logic exwr, input logic [4:0] exrd,
                                input logic memld, input logic [4:0] memrd,
                                input logic taken);
        in_t v;
        v = '{rs, rt, urs, urt, br, md, hilo, exld, exwr, exrd, memld, memrd, taken};
        return v;
    endfunction

    task automatic step(input logic r, input in_t v, input logic [5:0] e,
                        input logic [5:0] m, input string n);
        logic [5:0] ee, mm;
        string      nn;
        @(posedge clk);
        #1;
        rst           = r;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_use_rs     = v.urs;
        id_use_rt     = v.urt;
        id_is_branch  = v.br;
        id_is_muldiv  = v.md;
        id_reads_hilo = v.hilo;
        ex_mem_read   = v.exld;
        ex_reg_write  = v.exwr;
        ex_rd         = v.exrd;
        mem_mem_read  = v.memld;
        mem_rd        = v.memrd;
        br_taken      = v.taken;
        exp_q.push_back(e);
        msk_q.push_back(m);
        nm_q.push_back(n);
        if (r) exp_stalls = 0;
        else if (e[2]) exp_stalls++;
        @(negedge clk);
        ee = exp_q.pop_front();
        mm = msk_q.pop_front();
        nn = nm_q.pop_front();
        total++;
        if ((obs & mm) !== (ee & mm)) begin
            bad++;
            $display("FAIL %s: got %b want %b (mask %b)", nn, obs, ee, mm);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string n);
        total++;
        if (perf_stall_cnt !== 32'(exp_stalls)) begin
            bad++;
            $display("FAIL %s: perf_stall_cnt got %0d want %0d", n, perf_stall_cnt, exp_stalls);
        end
    endtask
`endif

    initial begin
        idle = vin(0,0,0,0,0,0,0,0,0,0,0,0,0);

        vecs[0]  = '{"idle",            idle,                                 RUN};
        vecs[1]  = '{"lu_rs",           vin(8,0,1,0,0,0,0,1,1,8,0,0,0),       STALL};
        vecs[2]  = '{"lu_rt_unused",    vin(0,5,0,0,0,0,0,1,1,5,0,0,0),       RUN};
        vecs[3]  = '{"lu_r0",           vin(0,0,0,1,0,0,0,1,1,0,0,0,0),       RUN};
        vecs[4]  = '{"lu_rt",           vin(0,5,0,1,0,0,0,1,1,5,0,0,0),       STALL};
        vecs[5]  = '{"alu_fwd_ok",      vin(9,0,1,0,0,0,0,0,1,9,0,0,0),       RUN};
        vecs[6]  = '{"bx_taken",        vin(0,9,0,1,1,0,0,0,1,9,0,0,1),       STALL};
        vecs[7]  = '{"br_mem_alu",      vin(0,9,0,1,1,0,0,0,0,0,0,9,1),       FLUSH};
        vecs[8]  = '{"bm_rs",           vin(10,0,1,0,1,0,0,0,0,0,1,10,0),     STALL};
        vecs[9]  = '{"bm_r0",           vin(0,0,1,0,1,0,0,0,0,0,1,0,1),       FLUSH};
        vecs[10] = '{"mem_ld_nobr",     vin(10,0,1,0,0,0,0,0,0,0,1,10,0),     RUN};
        vecs[11] = '{"br_nohaz",        vin(3,4,1,1,1,0,0,0,1,7,1,6,1),       FLUSH};
        vecs[12] = '{"stall_over_fl",   vin(8,0,1,0,1,0,0,1,1,8,0,0,1),       STALL};
        vecs[13] = '{"hilo_idle",       vin(0,0,0,0,0,0,1,0,0,0,0,0,0),       RUN};
        vecs[14] = '{"lu_nomatch",      vin(7,0,1,0,0,0,0,1,1,8,0,0,0),       RUN};
        vecs[15] = '{"bx_r0",           vin(0,0,0,1,1,0,0,0,1,0,0,0,1),       FLUSH};

        // reset: first sample may still see the pre-reset counter
        step(1'b1, idle, RSTO, 6'b111110, "rst0");
        step(1'b1, idle, RSTO, ALL, "rst1");
        step(1'b1, vin(0,0,0,0,1,1,1,0,0,0,0,0,1), RSTO, ALL, "rst_hold");
        step(1'b0, idle, RUN, ALL, "post_rst");
`ifdef HAZARD_PERF_EN
        check_perf("perf_after_rst");
`endif

        foreach (vecs[i]) step(1'b0, vecs[i].in, vecs[i].exp, ALL, vecs[i].name);

        // load-use clears once the load leaves EX
        step(1'b0, vin(8,0,1,0,0,0,0,1,1,8,0,0,0), STALL, ALL, "lu_seq0");
        step(1'b0, vin(8,0,1,0,0,0,0,0,0,0,1,8,0), RUN,   ALL, "lu_seq1");

        // load feeding a branch: bx then bm, then taken branch flushes
        step(1'b0, vin(10,0,1,0,1,0,0,1,1,10,0,0,1), STALL, ALL, "ldbr_ex");
        step(1'b0, vin(10,0,1,0,1,0,0,0,0,0,1,10,1), STALL, ALL, "ldbr_mem");
        step(1'b0, vin(10,0,1,0,1,0,0,0,0,0,0,10,1), FLUSH, ALL, "ldbr_go");

        // MULT held off by load-use must not launch
        step(1'b0, vin(8,0,1,0,0,1,0,1,1,8,0,0,0), STALL, ALL, "md_blocked");

        // MULT at T, MFLO T+1..T+4 stalled, proceeds T+5
        step(1'b0, vin(0,0,0,0,0,1,0,0,0,0,0,0,0), 6'b110010, ALL, "md_issue");
        for (int k = 1; k <= 4; k++)
            step(1'b0, vin(0,0,0,0,0,0,1,0,0,0,0,0,0), 6'b000101, ALL, $sformatf("mflo_wait%0d", k));
        step(1'b0, vin(0,0,0,0,0,0,1,0,0,0,0,0,0), RUN, ALL, "mflo_go");

        // back-to-back MULT waits out the first, then issues at T+5
        step(1'b0, vin(0,0,0,0,0,1,0,0,0,0,0,0,0), 6'b110010, ALL, "md2_issue");
        for (int k = 1; k <= 4; k++)
            step(1'b0, vin(0,0,0,0,0,1,0,0,0,0,0,0,0), 6'b000101, ALL, $sformatf("md2_wait%0d", k));
        step(1'b0, vin(0,0,0,0,0,1,0,0,0,0,0,0,0), 6'b110010, ALL, "md3_issue");

        // reset mid-op abandons it
        step(1'b0, idle, 6'b110001, ALL, "md3_busy");
        step(1'b1, idle, RSTO, 6'b111110, "md3_rst");
        step(1'b0, idle, RUN, ALL, "md3_after_rst");

        step(1'b0, vin(8,0,1,0,0,0,0,1,1,8,0,0,0), STALL, ALL, "perf_lu0");
        step(1'b0, vin(0,9,0,1,1,0,0,0,1,9,0,0,1), STALL, ALL, "perf_bx");
        step(1'b0, idle, RUN, ALL, "final_idle");
`ifdef HAZARD_PERF_EN
        check_perf("perf_count");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the 5-stage MIPS core; sits beside the forwarding unit in ID.
- Detects hazards that forwarding cannot cover: load-use, branch-compare-in-ID dependencies, and the multi-cycle MULT/DIV unit.
- Drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.
- Owns the MULT/DIV occupancy state machine.

Parameters:
- MD_LAT, 32, cycles the MULT/DIV unit is busy after issue; legal range 1..255.
- CNT_W, 8, width of the MULT/DIV down-counter; must satisfy 2^CNT_W > MD_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID instruction is BEQ/BNE (compare done in ID).
- id_is_muldiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes the GPR file.
- ex_rd  in  5  EX destination register.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_rd  in  5  MEM destination register.
- br_taken  in  1  branch in ID resolved taken.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- md_start  out  1  one-cycle MULT/DIV launch pulse.
- md_busy  out  1  MULT/DIV unit occupied.

Behaviour:
- Matches on rs and rt are gated by id_use_rs and id_use_rt. Register 0 never matches.
- Stall terms (combinational, same cycle):
  - lu = ex_mem_read && ex_rd!=0 && ex_rd matches rs or rt.
  - bx = id_is_branch && ex_reg_write && ex_rd!=0 && ex_rd matches rs or rt.
  - bm = id_is_branch && mem_mem_read && mem_rd!=0 && mem_rd matches rs or rt.
  - md = (id_is_muldiv || id_reads_hilo) && md_busy.
- stall = lu | bx | bm | md.
- When stall=1: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, md_start=0.
- When stall=0: pc_we=1, ifid_we=1, idex_bubble=0, ifid_flush=br_taken.
- Stall has priority over flush. br_taken is ignored while stalled because the branch operands are not yet valid.
- MULT/DIV FSM:
  - States: MD_IDLE (cnt==0), MD_BUSY (cnt!=0).
  - md_busy = (cnt!=0), driven from the register.
  - md_start = id_is_muldiv && !stall && !rst. It can only be high in MD_IDLE, because md forces a stall while busy.
  - On md_start, cnt loads MD_LAT. In MD_BUSY, cnt decrements by 1 each cycle.
  - With issue in cycle T, md_busy is high in cycles T+1..T+MD_LAT. A dependent MFHI/MFLO or MULT/DIV in ID at T+1 stalls exactly MD_LAT cycles and proceeds in cycle T+MD_LAT+1.
- Back-to-back stall causes: the lu/bx/bm stall clears one cycle after the producer advances. bx followed by bm gives 2 stall cycles for a load feeding a branch.
- Reset:
  - While rst=1: cnt=0, md_busy=0, md_start=0, pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=1.
  - Reset mid-MULT/DIV abandons the operation. The cycle after rst falls, md_busy=0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds output perf_stall_cnt [31:0], a 32-bit saturating count of cycles with stall=1. Cleared by rst; holds at 0xFFFFFFFF.
- When undefined, the port and counter do not exist.
- Stall and flush behaviour is identical either way.

Decomposition:
- Shared package holds:
  - MD_LAT default.
  - Encodings MD_IDLE/MD_BUSY.
  - Register-0 constant.
  - Localparam for the perf counter width (32).
- One natural sub-module: hazard_md_tracker, containing the MULT/DIV counter and FSM. Its interface is issue in, md_busy out.
- Comparators remain in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 -> stall 1 cycle (pc_we=0, idex_bubble=1); next cycle with ex_mem_read=0 -> pc_we=1.
- Register 0: ex_mem_read=1, ex_rd=0, id_rt=0, id_use_rt=1 -> no stall.
- Branch after ALU op: id_is_branch=1, ex_reg_write=1, ex_rd=9, id_rt=9, br_taken=1 -> ifid_flush=0 and stall. After the producer moves to MEM as a non-load -> stall=0, ifid_flush=1.
- Load then branch: MEM load to r10, branch in ID reads r10 -> bm stall 1 cycle; total 2 cycles when the load starts in EX.
- MULT/DIV, MD_LAT=4: MULT issues at T -> md_start=1 at T, md_busy=1 for T+1..T+4. MFLO in ID at T+1 -> stalled 4 cycles, pc_we=1 at T+5.
- Reset mid-op: rst=1 at T+2 of a MULT/DIV -> md_busy=0 at T+3. With HAZARD_PERF_EN, perf_stall_cnt=0 after reset and increments once per stall cycle.
